upower_mem_responder: RTL and testbench
=======================================

// Module: upower_mem_responder
// PURPOSE
//   Word-addressed memory responder serving the uPower core's load/store/fetch request port.
//   It is the responder end of the core's request/response interface: it accepts one request,
//   waits a programmable latency, then returns read data or a write acknowledgement.
//   It sits between the core and a synchronous RAM array, and replaces the ideal memory
//   used in core-level benches.
// PARAMETERS
//   DATA_W      32  data width in bits; fixed at 32 (4 byte lanes)
//   DEPTH_LOG2  10  log2 of memory depth in 32-bit words (default 1024 words = 4 KiB)
//   LATENCY     2   cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   req_valid  in   1   core presents a request
//   req_ready  out  1   responder can accept; high only in IDLE
//   req_we     in   1   1 = store, 0 = load/fetch
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data; big-endian lanes, [31:24] is the byte at addr+0
//   req_be     in   4   byte enables; be[3] is the byte at addr+0; ignored for loads
//   rsp_valid  out  1   response available
//   rsp_ready  in   1   core accepts the response
//   rsp_rdata  out  32  load data; 0 for stores and for errors
//   rsp_err    out  1   access fault: misaligned or out of range
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
//     - FSM -> IDLE, latency counter cleared
//     - first cycle after deassert: req_ready=1
//     - RAM contents are not reset and survive reset
//   FSM has three states: IDLE, WAIT, RESP.
//   IDLE:
//     - req_ready=1
//     - on req_valid & req_ready: latch we/addr/wdata/be, load counter with LATENCY-1
//     - if LATENCY==1 go to RESP, else go to WAIT
//   WAIT:
//     - req_ready=0; counter decrements each cycle
//     - at 0 -> RESP
//   RESP:
//     - rsp_valid=1; rsp_rdata/rsp_err stay stable until rsp_ready
//     - on rsp_valid & rsp_ready -> IDLE
//     - req_ready rises the following cycle; no request overlap, one outstanding max
//   Latency: accept at edge N gives rsp_valid high after edge N+LATENCY.
//   Errors:
//     - misaligned: addr[1:0]!=0 -> rsp_err=1
//     - out of range: addr[31:DEPTH_LOG2+2]!=0 -> rsp_err=1
//     - on error: no RAM write, rsp_rdata=0
//   Stores:
//     - RAM written only on the accept edge, per enabled byte lane
//     - be=0000 is a legal no-op store with rsp_err=0
//   Loads: RAM read at accept; data held in a response register; later stores cannot alter it.
//   rsp_ready high with no rsp_valid has no effect.
//   req_valid in WAIT/RESP is ignored; the core must hold it until req_ready.
//   Reset mid-transaction: pending response is discarded; a store accepted before reset stays committed.
//   Word index = addr[DEPTH_LOG2+1:2]; no wrap-around, out-of-range never aliases.
// TESTING
//   1. Reset then store 0x11223344 to 0x10 with be=1111; load 0x10
//      -> rdata=0x11223344, err=0, rsp_valid exactly LATENCY cycles after accept.
//   2. Store be=1000, wdata=0xAA000000 to 0x10; load 0x10 -> rdata=0xAA223344.
//   3. Load 0x12 -> err=1, rdata=0.
//      Store to 0x1000 (DEPTH_LOG2=10) -> err=1; word 0 unchanged.
//   4. Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid/rdata stable, req_ready=0 throughout;
//      req_ready=1 one cycle after the handshake.
//   5. Assert reset_n=0 in WAIT -> rsp_valid=0 immediately; next load returns the pre-reset stored value.
//   6. LATENCY=1 build -> back-to-back load/load with rsp_ready tied high yields one response every 2 cycles.

Source files
------------

// File: rtl/upower_mem_responder_if.sv
// Request/response bus between the uPower core (master) and its memory responder (slave).
interface upower_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/upower_mem_responder.sv
// Word-addressed memory responder for the uPower core: one outstanding request,
// programmable response latency, byte-lane stores and fault reporting.
module upower_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  upower_mem_responder_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LANES = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [3:0]            cnt;
  logic                  ready_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_W-1:0]     mem [DEPTH];

  // Misaligned or beyond the array; out-of-range addresses never alias onto real words.
  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:DEPTH_LOG2+2] != '0);
  endfunction

  assign accept   = bus.req_valid && ready_q;
  assign fault    = addr_fault(bus.req_addr);
  assign word_idx = bus.req_addr[DEPTH_LOG2+1:2];

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control and response register: ready is registered so it stays low while in reset
  // and rises on the first edge after reset or after a response handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      if (accept) begin
        cnt     <= CNT_LOAD;
        err_q   <= fault;
        rdata_q <= (!bus.req_we && !fault) ? mem[word_idx] : '0;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // RAM array: not reset, written only on the accept edge of a fault-free store.
  always_ff @(posedge clock) begin
    if (accept && bus.req_we && !fault) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_be[i]) mem[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_upower_mem_responder.sv
// Directed bench for upower_mem_responder: LATENCY=2 instance for function checks,
// LATENCY=1 instance for back-to-back throughput.
module tb_upower_mem_responder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  upower_mem_responder_if bus ();
  upower_mem_responder_if bus1 ();

  upower_mem_responder #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(2)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  upower_mem_responder #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    int n;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output int lat, output logic [31:0] rdata,
                      output logic err);
    start_req(we, addr, wdata, be);
    wait_rsp(lat);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    finish_rsp();
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          highs;
    int          toggles;
    logic        prev;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.rsp_ready  = 1'b0;
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 32'h0;
    bus1.req_wdata = '0;
    bus1.req_be    = '0;
    bus1.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Full-word store then load, with latency measurement
    xact(1'b1, 32'h10, 32'h11223344, 4'b1111, lat, rd, er);
    check("st_latency", 32'(lat), 32'd2);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'h0);
    check("ready_after_hs", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
    check("ld_latency", 32'(lat), 32'd2);
    check("ld_rdata", rd, 32'h11223344);
    check("ld_err", 32'(er), 32'd0);

    // Single-lane store on the addr+0 byte
    xact(1'b1, 32'h10, 32'hAA000000, 4'b1000, lat, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
    check("ld_byte_merge", rd, 32'hAA223344);

    // Faults: misaligned load, out-of-range stores must not touch the array
    xact(1'b0, 32'h12, 32'h0, 4'b0000, lat, rd, er);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'h0);
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, lat, rd, er);
    xact(1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111, lat, rd, er);
    check("oor_err", 32'(er), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
    check("word0_unchanged", rd, 32'hCAFEF00D);
    xact(1'b1, 32'h80000010, 32'h0, 4'b1111, lat, rd, er);
    check("oor_high_err", 32'(er), 32'd1);
    xact(1'b1, 32'h10, 32'h55555555, 4'b0000, lat, rd, er);
    check("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
    check("no_alias_no_be0", rd, 32'hAA223344);

    // rsp_ready with nothing pending does nothing
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("idle_rsp_ready", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);

    // Back-pressure: response held stable, no new accept
    start_req(1'b0, 32'h10, 32'h0, 4'b0000);
    wait_rsp(lat);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid_ready", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
      check("hold_rdata", bus.rsp_rdata, 32'hAA223344);
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    check("ready_after_hold", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
    check("ignored_store", rd, 32'hAA223344);

    // Reset in WAIT: store accepted before reset stays committed
    xact(1'b1, 32'h20, 32'h5A5A5A5A, 4'b1111, lat, rd, er);
    start_req(1'b1, 32'h24, 32'h77665544, 4'b1111);
    reset_n = 1'b0;
    #1;
    check("rst_wait_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_wait_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset in RESP drops the pending response at once
    start_req(1'b0, 32'h20, 32'h0, 4'b0000);
    wait_rsp(lat);
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_resp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    xact(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, er);
    check("survive_rst_20", rd, 32'h5A5A5A5A);
    xact(1'b0, 32'h24, 32'h0, 4'b0000, lat, rd, er);
    check("committed_24", rd, 32'h77665544);

    // LATENCY=1 instance: one response every 2 cycles
    highs   = 0;
    toggles = 0;
    prev    = bus1.rsp_valid;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus1.rsp_valid) highs++;
      if (bus1.rsp_valid != prev) toggles++;
      prev = bus1.rsp_valid;
    end
    check("lat1_responses", 32'(highs), 32'd5);
    check("lat1_alternate", 32'(toggles), 32'd10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
